// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - shared opcodes, function codes, FSM state and decode helpers for the MIPS16 front end
package mips16_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_SLTI  = 3'b001;
  localparam logic [2:0] OP_J     = 3'b010;
  localparam logic [2:0] OP_JAL   = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_ADDI  = 3'b111;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;

  localparam logic [2:0] RA_REG = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  function automatic logic [15:0] sext7(input logic [6:0] imm);
    return {{9{imm[6]}}, imm};
  endfunction

  // Opcodes 100/101 are unassigned; R-type only defines add/sub/and/or.
  function automatic logic is_illegal(input logic [2:0] op, input logic [3:0] fn);
    logic ill;
    ill = 1'b0;
    case (op)
      3'b100, 3'b101: ill = 1'b1;
      OP_RTYPE:       ill = (fn > FN_OR);
      default:        ill = 1'b0;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/mips16_regfile.sv
// rtl/mips16_regfile.sv - 8x16 register file, two async read ports, one sync write port, r0 hardwired zero
module mips16_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr1,
  input  logic [2:0]  raddr2,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2
);

  logic [15:0] mem [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we && (waddr != 3'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 3'd0) ? 16'h0000 : mem[raddr1];
  assign rdata2 = (raddr2 == 3'd0) ? 16'h0000 : mem[raddr2];

endmodule

// File: rtl/mips16_issue_unit.sv
// rtl/mips16_issue_unit.sv - fetch/decode/issue front end driving the mips_16 operand bus, with writeback and PC update
module mips16_issue_unit
  import mips16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [2:0]  opcode,
  output logic [3:0]  Function,
  output logic [15:0] reg1,
  output logic [15:0] reg2,
  output logic [15:0] L,
  output logic [15:0] LJ,
  input  logic [15:0] alu_result,
  input  logic [15:0] pc_out,
  output logic [15:0] pc,
  output logic        retired,
  output logic        illegal
);

  state_t      state, state_nx;
  logic [15:0] ir, alu_q, pcout_q;
  logic [15:0] rs_val, rt_val, pc_inc, next_pc, wb_data;
  logic [2:0]  ir_op, ir_rs, ir_rt, ir_rd, wb_addr;
  logic        wb_en, ir_illegal;

  assign ir_op      = ir[15:13];
  assign ir_rs      = ir[12:10];
  assign ir_rt      = ir[9:7];
  assign ir_rd      = ir[6:4];
  assign ir_illegal = is_illegal(ir_op, ir[3:0]);
  assign pc_inc     = pc + 16'd1;
  assign imem_addr  = pc;

  mips16_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en && (state == ST_WB)),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (ir_rs),
    .raddr2 (ir_rt),
    .rdata1 (rs_val),
    .rdata2 (rt_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (run) state_nx = ST_FETCH;
      ST_FETCH:  if (imem_ack) state_nx = ST_DECODE;
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC:   state_nx = ST_WB;
      ST_WB:     state_nx = run ? ST_FETCH : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == ST_FETCH);
    retired  = (state == ST_WB);
    illegal  = (state == ST_WB) && ir_illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ir <= '0;
    else if ((state == ST_FETCH) && imem_ack) ir <= imem_rdata;
  end

  // Operand bus is only touched on DECODE exit so mips_16 sees stable inputs through WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode   <= '0;
      Function <= '0;
      reg1     <= '0;
      reg2     <= '0;
      L        <= '0;
      LJ       <= '0;
    end else if (state == ST_DECODE) begin
      opcode   <= ir_op;
      Function <= ir[3:0];
      reg1     <= rs_val;
      reg2     <= rt_val;
      L        <= (ir_op == OP_BEQ) ? (pc_inc + sext7(ir[6:0])) : sext7(ir[6:0]);
      LJ       <= {pc[15:13], ir[12:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q   <= '0;
      pcout_q <= '0;
    end else if (state == ST_EXEC) begin
      alu_q   <= alu_result;
      pcout_q <= pc_out;
    end
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = ir_rd;
    wb_data = alu_q;
    next_pc = pc_inc;
    case (ir_op)
      OP_RTYPE: wb_en = !ir_illegal;
      OP_SLTI, OP_ADDI: begin
        wb_en   = 1'b1;
        wb_addr = ir_rt;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_addr = RA_REG;
        wb_data = pc_inc;
        next_pc = pcout_q;
      end
      OP_J:    next_pc = pcout_q;
      OP_BEQ:  next_pc = (reg1 == reg2) ? pcout_q : pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else if (state == ST_WB) pc <= next_pc;
  end

endmodule

// File: tb/tb_mips16_issue_unit.sv
// tb/tb_mips16_issue_unit.sv - scoreboard bench for mips16_issue_unit with a behavioural mips_16 peer
module tb_mips16_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_req, imem_ack, retired, illegal;
  logic [15:0] imem_addr, imem_rdata, reg1, reg2, L, LJ, alu_result, pc_out, pc;
  logic [2:0]  opcode;
  logic [3:0]  Function;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  fn;
    logic [15:0] r1, r2, l, lj, npc;
    logic        ill;
    int          ack_cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        last_exp;
  logic [15:0] mr [8];
  logic [15:0] mpc;
  logic [15:0] pc_exp;
  logic        pc_pend = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips16_issue_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opcode(opcode), .Function(Function), .reg1(reg1), .reg2(reg2), .L(L), .LJ(LJ),
    .alu_result(alu_result), .pc_out(pc_out), .pc(pc), .retired(retired), .illegal(illegal)
  );

  // Behavioural mips_16 responder.
  always_comb begin
    alu_result = 16'h0000;
    pc_out     = pc + 16'd1;
    case (opcode)
      3'b000: case (Function)
        4'd0: alu_result = reg1 + reg2;
        4'd1: alu_result = reg1 - reg2;
        4'd2: alu_result = reg1 & reg2;
        4'd3: alu_result = reg1 | reg2;
        default: alu_result = 16'h0000;
      endcase
      3'b001: alu_result = ($signed(reg1) < $signed(L)) ? 16'd1 : 16'd0;
      3'b111: alu_result = reg1 + L;
      3'b010, 3'b011: pc_out = LJ;
      3'b110: pc_out = L;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_exp = '{default: 0};
      pc_pend  = 1'b0;
    end else begin
      if (pc_pend) begin
        check("pc", pc, pc_exp);
        pc_pend = 1'b0;
      end
      check("illegal_without_retired", illegal & ~retired, 0);
      if (retired) begin
        if (sbq.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("opcode", opcode, e.op);
          check("Function", Function, e.fn);
          check("reg1", reg1, e.r1);
          check("reg2", reg2, e.r2);
          check("L", L, e.l);
          check("LJ", LJ, e.lj);
          check("illegal", illegal, e.ill);
          check("latency", cyc - e.ack_cyc, 3);
          last_exp = e;
          pc_exp   = e.npc;
          pc_pend  = 1'b1;
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
    mpc = 16'h0000;
  endtask

  // Wait for a fetch, optionally stall, then return instr and push its expected effects.
  task automatic serve(input logic [15:0] instr, input int waits);
    exp_t        e;
    logic [15:0] sx, wv;
    logic [2:0]  wa;
    logic        we;
    int          n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      check("req_timeout", 0, 1);
      return;
    end
    check("imem_addr", imem_addr, mpc);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      check("stall_req", imem_req, 1);
      check("stall_addr", imem_addr, mpc);
      check("stall_opcode", opcode, last_exp.op);
      check("stall_L", L, last_exp.l);
    end
    e.op  = instr[15:13];
    e.fn  = instr[3:0];
    e.r1  = mr[instr[12:10]];
    e.r2  = mr[instr[9:7]];
    sx    = {{9{instr[6]}}, instr[6:0]};
    e.l   = (e.op == 3'b110) ? mpc + 16'd1 + sx : sx;
    e.lj  = {mpc[15:13], instr[12:0]};
    e.ill = (e.op == 3'b100) || (e.op == 3'b101) || (e.op == 3'b000 && instr[3:0] > 4'd3);
    e.ack_cyc = cyc;
    we = 1'b0; wa = 3'd0; wv = 16'h0000;
    case (e.op)
      3'b000: if (!e.ill) begin
        we = 1'b1; wa = instr[6:4];
        case (instr[1:0])
          2'd0: wv = e.r1 + e.r2;
          2'd1: wv = e.r1 - e.r2;
          2'd2: wv = e.r1 & e.r2;
          default: wv = e.r1 | e.r2;
        endcase
      end
      3'b001: begin we = 1'b1; wa = instr[9:7]; wv = ($signed(e.r1) < $signed(e.l)) ? 16'd1 : 16'd0; end
      3'b111: begin we = 1'b1; wa = instr[9:7]; wv = e.r1 + e.l; end
      3'b011: begin we = 1'b1; wa = 3'd7; wv = mpc + 16'd1; end
      default: ;
    endcase
    case (e.op)
      3'b010, 3'b011: e.npc = e.lj;
      3'b110:         e.npc = (e.r1 == e.r2) ? e.l : mpc + 16'd1;
      default:        e.npc = mpc + 16'd1;
    endcase
    if (we && wa != 3'd0) mr[wa] = wv;
    mpc = e.npc;
    sbq.push_back(e);
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_pc", pc, 16'h0000);
    check("rst_retired", retired, 0);
    check("rst_opcode", opcode, 0);
    check("rst_L", L, 0);
    check("rst_LJ", LJ, 0);
    rst_n = 1'b1;
    // Stray ack outside FETCH must be ignored.
    imem_ack = 1'b1; imem_rdata = 16'h8000;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    check("idle_no_req", imem_req, 0);
    run = 1'b1;

    serve(16'hE085, 0);  // addi r1,r0,5
    serve(16'hE101, 0);  // addi r2,r0,1
    serve(16'hE082, 0);  // addi r1,r0,2
    serve(16'h0530, 0);  // add r3,r1,r2
    serve(16'h0531, 0);  // sub r3,r1,r2
    serve(16'h0C00, 0);  // reads r3
    serve(16'h0500, 0);  // add r0,r1,r2 (discarded)
    serve(16'h0000, 0);  // reads r0
    serve(16'h4004, 0);  // j 4
    serve(16'hC003, 0);  // beq r0,r0,+3 taken
    serve(16'hE085, 0);
    serve(16'h4004, 0);
    serve(16'hC403, 0);  // beq r1,r0 not taken
    serve(16'h2607, 0);  // slti r4,r1,7
    serve(16'h1000, 0);  // reads r4
    serve(16'h4010, 0);
    serve(16'h600A, 0);  // jal
    serve(16'h400A, 0);  // j
    serve(16'h1C00, 0);  // reads r7
    serve(16'hE0FD, 3);  // addi r1,r0,-3 after a 3-cycle stall
    serve(16'h8000, 0);  // illegal opcode
    serve(16'h003F, 0);  // illegal funct, rd=3 must not be written
    serve(16'h0C00, 0);
    serve(16'h4000, 0);
    serve(16'hC07E, 0);  // beq to 0xFFFF
    serve(16'hE085, 0);  // PC wraps to 0

    serve(16'hE101, 0);
    @(negedge clk);      // EXEC
    run = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("no_req_after_run_drop", imem_req, 0);
    end
    check("run_drop_retired", sbq.size(), 0);
    run = 1'b1;

    begin
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("stall_req_seen", imem_req, 1);
      check("stall_addr_before_reset", imem_addr, mpc);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_req_drop", imem_req, 0);
    check("async_pc", pc, 16'h0000);
    check("async_opcode", opcode, 0);
    check("async_reg1", reg1, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    serve(16'h0C00, 0);  // r3 cleared by reset
    serve(16'hE085, 0);

    begin
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 30) begin
        @(negedge clk);
        n++;
      end
      check("drain", sbq.size(), 0);
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips16_issue_unit.md
# mips16_issue_unit

Instruction fetch/decode/issue front end for the 16-bit MIPS core. It fetches instruction words from instruction memory over a req/ack handshake and decodes them against an internal 8×16 register file. It drives the operand/opcode bus of `mips_16` (opcode, Function, reg1, reg2, L, LJ), then samples `alu_result`/`pc_out` to perform writeback and PC update. It is the initiator that `mips_16` responds to.

## Interface
- `RESET_PC`, 16'h0000, PC loaded on reset
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `run`  in  1  level; permits fetch of next instruction
- `imem_req`  out  1  fetch request
- `imem_addr`  out  16  word address (= PC)
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle
- `imem_rdata`  in  16  instruction word
- `opcode`  out  3  to `mips_16`
- `Function`  out  4  to `mips_16`
- `reg1`  out  16  rs value
- `reg2`  out  16  rt value
- `L`  out  16  sign-extended imm7 (addi/slti) or absolute branch target (beq)
- `LJ`  out  16  jump target `{PC[15:13], instr[12:0]}`
- `alu_result`  in  16  from `mips_16`
- `pc_out`  in  16  from `mips_16`
- `pc`  out  16  current PC
- `retired`  out  1  one-cycle pulse per completed instruction
- `illegal`  out  1  one-cycle pulse, with `retired`, on an illegal instruction

## Operation
- Formats: `[15:13]` op; R: rs`[12:10]` rt`[9:7]` rd`[6:4]` funct`[3:0]`; I: rs, rt, imm7`[6:0]`; J: target`[12:0]`.
- Opcodes:
  - 000 R-type: funct 0 add, 1 sub, 2 and, 3 or → rd.
  - 001 slti → rt.
  - 010 j.
  - 011 jal: r7 ← PC+1, computed locally.
  - 110 beq.
  - 111 addi → rt.
  - 100, 101, and R-type funct 4–15 are illegal.
- Register file: r0 reads 0; writes to r0 are discarded.
- FSM IDLE → FETCH → DECODE → EXEC → WB:
  - IDLE: leave when `run`=1.
  - FETCH: `imem_req`=1 and `imem_addr`=PC, held stable until `imem_ack`; on ack, latch the IR and go to DECODE.
  - DECODE: read registers and register all datapath outputs. For beq, L = PC+1+sext(imm7). For other opcodes, L = sext(imm7). Function = IR`[3:0]` for every opcode.
  - EXEC: `mips_16` evaluates; sample `alu_result` and `pc_out` at the end of the cycle.
  - WB: write the register file; update PC; pulse `retired`. Then go to FETCH if `run`=1, else IDLE.
- Next PC:
  - j/jal: `pc_out`.
  - beq: `pc_out` if reg1==reg2, else PC+1.
  - All other instructions: PC+1.
- Illegal instruction: no register write, PC+1, pulse `illegal`.
- PC arithmetic is mod 2^16; 0xFFFF+1 wraps to 0x0000.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, all outputs 0, register file cleared.
- Reset mid-operation: `imem_req` drops asynchronously; any in-flight instruction is discarded without writeback.
- Latency: 4 cycles per instruction with same-cycle ack (FETCH, DECODE, EXEC, WB); each wait cycle in FETCH adds 1.
- `imem_ack` may arrive in the first FETCH cycle. `imem_ack` outside FETCH is ignored.
- Datapath outputs change only on DECODE exit and are stable from EXEC through the next DECODE.
- `run` deasserted mid-instruction: the instruction completes through WB; no new `imem_req`.
- `pc` updates on WB exit; `retired` is high exactly during WB.

## Structure
- `mips16_pkg`:
  - opcode constants `OP_RTYPE`, `OP_SLTI`, `OP_J`, `OP_JAL`, `OP_BEQ`, `OP_ADDI`
  - funct constants `FN_ADD`..`FN_OR`
  - FSM state type
  - register index `RA_REG`=7
- Sub-module `mips16_regfile`: 8×16, 2 async read ports, 1 sync write port, r0 hardwired zero, async active-low clear.
- Decode and next-PC logic live in the top level.

## Test plan
- Reset, `run`=1, imem returns 0xE085 (addi r1,r0,5) with the `mips_16` model → `imem_addr`=0x0000, opcode=111, reg1=0, L=0x0005; r1=5, pc=0x0001, `retired` 4 cycles after first req.
- Preload r1=2, r2=1; fetch 0x0530 (add r3,r1,r2) → Function=0000, reg1=2, reg2=1, r3=3; follow with funct 0001 → r3=1.
- At pc=4, fetch 0xC003 (beq r0,r0,+3) → L=0x0008, pc=0x0008. Then with r1=5, fetch 0xC403 at pc=4 → not taken, pc=0x0005.
- At pc=0x0010, fetch 0x600A (jal) → LJ=0x000A, r7=0x0011, pc=0x000A. Fetch 0x400A (j) → pc=0x000A, no register write.
- Withhold `imem_ack` 3 cycles → `imem_addr` stable and datapath outputs unchanged. Assert `rst_n`=0 during the stall → `imem_req`=0 immediately, pc=`RESET_PC`.
- Fetch 0x8000 → `illegal` and `retired` pulse together, no register write, pc+1. Drop `run` during EXEC → instruction retires, no further `imem_req`.
